clock_gate_ctrl: RTL and testbench



---
 rtl/clock_gate_ctrl.sv | 118 +++++++++++
 tb/tb_clock_gate_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_gate_ctrl.sv
// Clock-gate enable controller: gates the downstream domain after a run of idle
// cycles, re-enables on activity or wake request, and acknowledges once settled.
module clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              sleep_allow,
  input  logic              wake_req,
  output logic              cg_enable,
  output logic              wake_ack,
  output logic              gated,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_GATED,
    ST_WAKE
  } state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic          ack_done;
  logic          idle;
  logic          ack_now;

  always_comb begin
    idle    = !busy && !wake_req && sleep_allow;
    ack_now = 1'b0;
    if (wake_req && !ack_done) begin
      if (state == ST_RUN) begin
        ack_now = 1'b1;
      end else if (state == ST_WAKE && wake_cnt == WAKE_LAST) begin
        ack_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      cg_enable    <= 1'b1;
      wake_ack     <= 1'b0;
      gated        <= 1'b0;
      gated_cycles <= '0;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      ack_done     <= 1'b0;
    end else begin
      wake_ack <= ack_now;
      // A held request is acknowledged once; dropping it re-arms the handshake.
      ack_done <= wake_req && (ack_done || ack_now);

      case (state)
        ST_RUN: begin
          cg_enable <= 1'b1;
          gated     <= 1'b0;
          if (!idle) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state     <= ST_GATED;
            idle_cnt  <= '0;
            cg_enable <= 1'b0;
            gated     <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end

        ST_GATED: begin
          if (!idle) begin
            state     <= ST_WAKE;
            wake_cnt  <= '0;
            cg_enable <= 1'b1;
            gated     <= 1'b0;
          end else begin
            cg_enable <= 1'b0;
            gated     <= 1'b1;
            if (gated_cycles != '1) begin
              gated_cycles <= gated_cycles + STAT_W'(1);
            end
          end
        end

        ST_WAKE: begin
          cg_enable <= 1'b1;
          gated     <= 1'b0;
          if (wake_cnt == WAKE_LAST) begin
            state    <= ST_RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + WW'(1);
          end
        end

        default: begin
          state     <= ST_RUN;
          cg_enable <= 1'b1;
          gated     <= 1'b0;
          idle_cnt  <= '0;
          wake_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against an abstract model of the gating rules.
module tb_clock_gate_ctrl;

  localparam int IDLE_N  = 8;
  localparam int WAKE_N  = 2;
  localparam int STAT_N  = 4;
  localparam int STAT_MAX = (1 << STAT_N) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic              sleep_allow;
  logic              wake_req;
  logic              cg_enable;
  logic              wake_ack;
  logic              gated;
  logic [STAT_N-1:0] gated_cycles;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ack_count = 0;

  clock_gate_ctrl #(
    .IDLE_CYCLES(IDLE_N),
    .WAKE_CYCLES(WAKE_N),
    .STAT_W     (STAT_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .sleep_allow (sleep_allow),
    .wake_req    (wake_req),
    .cg_enable   (cg_enable),
    .wake_ack    (wake_ack),
    .gated       (gated),
    .gated_cycles(gated_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Abstract model: gating is a flag, settling is a countdown of remaining edges.
  bit m_started  = 0;
  bit m_is_gated = 0;
  int m_settle   = 0;
  int m_idle_run = 0;
  int m_gcount   = 0;
  bit m_served   = 0;
  bit m_ack      = 0;

  always @(posedge clk) begin
    bit idle_s;
    idle_s = !busy && !wake_req && sleep_allow;
    m_ack  = 0;
    if (rst) begin
      m_is_gated = 0;
      m_settle   = 0;
      m_idle_run = 0;
      m_gcount   = 0;
      m_served   = 0;
    end else begin
      if (m_settle > 0) begin
        m_settle = m_settle - 1;
        if (m_settle == 0) begin
          m_idle_run = 0;
          m_ack = wake_req && !m_served;
        end
      end else if (m_is_gated) begin
        if (idle_s) begin
          m_gcount = (m_gcount + 1 > STAT_MAX) ? STAT_MAX : m_gcount + 1;
        end else begin
          m_is_gated = 0;
          m_settle   = WAKE_N;
        end
      end else begin
        m_ack      = wake_req && !m_served;
        m_idle_run = idle_s ? m_idle_run + 1 : 0;
        if (m_idle_run == IDLE_N) begin
          m_is_gated = 1;
          m_idle_run = 0;
        end
      end
      m_served = wake_req && (m_served || m_ack);
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_cg_enable", int'(cg_enable), int'(!m_is_gated));
      check("model_gated", int'(gated), int'(m_is_gated));
      check("model_wake_ack", int'(wake_ack), int'(m_ack));
      check("model_gated_cycles", int'(gated_cycles), m_gcount);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (wake_ack) ack_count++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; busy = 1'b1; sleep_allow = 1'b1; wake_req = 1'b0;
    step(); step();
    check("reset_cg_enable", int'(cg_enable), 1);
    check("reset_wake_ack", int'(wake_ack), 0);
    check("reset_gated", int'(gated), 0);
    check("reset_gated_cycles", int'(gated_cycles), 0);

    // Idle gating after exactly eight idle edges
    rst = 1'b0; busy = 1'b0;
    repeat (7) step();
    check("idle7_cg_enable", int'(cg_enable), 1);
    step();
    check("idle8_cg_enable", int'(cg_enable), 0);
    check("idle8_gated", int'(gated), 1);

    // Wake from gated after ten gated cycles
    repeat (10) step();
    check("gated10_count", int'(gated_cycles), 10);
    wake_req = 1'b1; ack_count = 0;
    step();
    check("wake_cg_enable", int'(cg_enable), 1);
    check("wake_gated", int'(gated), 0);
    check("wake_ack_early0", int'(wake_ack), 0);
    step();
    check("wake_ack_early1", int'(wake_ack), 0);
    step();
    check("wake_ack_settled", int'(wake_ack), 1);
    check("wake_gated_cycles", int'(gated_cycles), 10);
    wake_req = 1'b0;
    step();
    check("wake_ack_count", ack_count, 1);

    // Idle restart: busy on the fifth idle cycle
    busy = 1'b1; step();
    busy = 1'b0; repeat (4) step();
    busy = 1'b1; step();
    busy = 1'b0;
    repeat (7) step();
    check("restart7_cg_enable", int'(cg_enable), 1);
    step();
    check("restart8_cg_enable", int'(cg_enable), 0);
    // Single busy pulse; idle inputs during settle must not re-gate
    busy = 1'b1; step();
    check("busy_exit_cg_enable", int'(cg_enable), 1);
    busy = 1'b0; step(); step();
    check("settle_no_regate", int'(gated), 0);
    check("busy_exit_count", int'(gated_cycles), 10);

    // sleep_allow low never gates
    sleep_allow = 1'b0;
    repeat (20) step();
    check("nosleep_cg_enable", int'(cg_enable), 1);
    check("nosleep_gated", int'(gated), 0);
    sleep_allow = 1'b1; busy = 1'b1; step();

    // RUN handshake: held request gives one ack with latency 1
    wake_req = 1'b1; ack_count = 0;
    step();
    check("run_ack_latency", int'(wake_ack), 1);
    repeat (4) step();
    check("run_ack_once", ack_count, 1);
    wake_req = 1'b0; step();
    wake_req = 1'b1; ack_count = 0;
    repeat (3) step();
    check("run_ack_rearm", ack_count, 1);
    wake_req = 1'b0; step();

    // Reset mid-WAKE
    busy = 1'b1; step();
    busy = 1'b0; repeat (8) step();
    check("pre_rst_gated", int'(gated), 1);
    wake_req = 1'b1; step();
    rst = 1'b1; step();
    check("rstwake_cg_enable", int'(cg_enable), 1);
    check("rstwake_gated_cycles", int'(gated_cycles), 0);
    check("rstwake_wake_ack", int'(wake_ack), 0);
    rst = 1'b0; wake_req = 1'b0; step();
    check("rstwake_after_ack", int'(wake_ack), 0);

    // Saturation at all-ones
    busy = 1'b1; step();
    busy = 1'b0; repeat (8) step();
    repeat (20) step();
    check("sat_gated_cycles", int'(gated_cycles), 15);

    // busy and wake_req together: one WAKE entry, one ack
    busy = 1'b1; wake_req = 1'b1; ack_count = 0;
    step();
    check("combo_cg_enable", int'(cg_enable), 1);
    step(); step();
    check("combo_wake_ack", int'(wake_ack), 1);
    wake_req = 1'b0; busy = 1'b0;
    step(); step();
    check("combo_ack_count", ack_count, 1);
    check("sat_hold_after", int'(gated_cycles), 15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
